// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle assembler.
package tri_pkg;
  localparam int WII    = 8;
  localparam int WIF    = 8;
  localparam int W      = WII + WIF;
  localparam int SETTLE = 4;
  localparam int SHW    = 6;
  localparam int IDW    = 16;
  // Counter only needs to hold SETTLE-1; keep at least one bit.
  localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic MODE_LIST  = 1'b0;
  localparam logic MODE_STRIP = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SETTLE  = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } vertex_t;
endpackage

// File: rtl/tri_settle_cnt.sv
// Settle-window down-counter: load on entry, count to zero, then hold.
module tri_settle_cnt
  import tri_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);
endmodule

// File: rtl/tri_assembler.sv
// Assembles list/strip vertex streams into triangles, drives the lighting
// stage for a settle window, then hands triangle + shade downstream.
module tri_assembler
  import tri_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             vtx_valid,
  output logic             vtx_ready,
  input  logic [W-1:0]     vtx_x,
  input  logic [W-1:0]     vtx_y,
  input  logic [W-1:0]     vtx_z,
  input  logic             vtx_last,
  output logic [W-1:0]     light_ax,
  output logic [W-1:0]     light_ay,
  output logic [W-1:0]     light_az,
  output logic [W-1:0]     light_bx,
  output logic [W-1:0]     light_by,
  output logic [W-1:0]     light_bz,
  output logic [W-1:0]     light_cx,
  output logic [W-1:0]     light_cy,
  output logic [W-1:0]     light_cz,
  input  logic [SHW-1:0]   light_shade,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [9*W-1:0]   tri_vtx,
  output logic [SHW-1:0]   tri_shade,
  output logic [IDW-1:0]   tri_id,
  output logic             err_partial
);
  state_t         state_reg, state_next;
  vertex_t        p0_reg, p0_next, p1_reg, p1_next;
  vertex_t        a_reg, a_next, b_reg, b_next, c_reg, c_next;
  logic [1:0]     vc_reg, vc_next;
  logic           par_reg, par_next;
  logic           mode_reg, mode_next;
  logic           fresh_reg, fresh_next;
  logic [SHW-1:0] shade_reg, shade_next;
  logic [IDW-1:0] id_reg, id_next;
  logic           err_reg, err_next;
  logic           load_cnt, cnt_zero;
  logic           cur_mode;
  vertex_t        nv;

  tri_settle_cnt u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (load_cnt),
    .load_val (CW'(SETTLE - 1)),
    .zero     (cnt_zero)
  );

  assign nv       = '{x: vtx_x, y: vtx_y, z: vtx_z};
  // Mode is sampled only on the first vertex of a primitive.
  assign cur_mode = fresh_reg ? mode : mode_reg;

  always_comb begin
    state_next = state_reg;
    p0_next    = p0_reg;
    p1_next    = p1_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    vc_next    = vc_reg;
    par_next   = par_reg;
    mode_next  = mode_reg;
    fresh_next = fresh_reg;
    shade_next = shade_reg;
    id_next    = id_reg;
    err_next   = err_reg;
    load_cnt   = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_COLLECT;
      S_COLLECT: begin
        if (vtx_valid) begin
          fresh_next = 1'b0;
          mode_next  = cur_mode;
          if (vc_reg < 2'd2) begin
            if (cur_mode == MODE_LIST) begin
              if (vc_reg == 2'd0) p0_next = nv;
              else                p1_next = nv;
            end else begin
              p0_next = p1_reg;
              p1_next = nv;
            end
            vc_next = vc_reg + 2'd1;
          end else begin
            c_next     = nv;
            state_next = S_SETTLE;
            load_cnt   = 1'b1;
            if (cur_mode == MODE_LIST) begin
              a_next  = p0_reg;
              b_next  = p1_reg;
              vc_next = 2'd0;
            end else begin
              // Odd strip triangles swap a/b to keep winding consistent.
              a_next   = par_reg ? p1_reg : p0_reg;
              b_next   = par_reg ? p0_reg : p1_reg;
              p0_next  = p1_reg;
              p1_next  = nv;
              par_next = ~par_reg;
            end
          end
          if (vtx_last) begin
            vc_next    = 2'd0;
            par_next   = 1'b0;
            fresh_next = 1'b1;
            if (vc_reg < 2'd2) err_next = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          shade_next = light_shade;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (tri_ready) begin
          id_next    = id_reg + 1'b1;
          state_next = S_COLLECT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      p0_reg    <= '0;
      p1_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      vc_reg    <= 2'd0;
      par_reg   <= 1'b0;
      mode_reg  <= MODE_LIST;
      fresh_reg <= 1'b1;
      shade_reg <= '0;
      id_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      p0_reg    <= p0_next;
      p1_reg    <= p1_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      vc_reg    <= vc_next;
      par_reg   <= par_next;
      mode_reg  <= mode_next;
      fresh_reg <= fresh_next;
      shade_reg <= shade_next;
      id_reg    <= id_next;
      err_reg   <= err_next;
    end
  end

  assign vtx_ready   = (state_reg == S_COLLECT);
  assign tri_valid   = (state_reg == S_OUT);
  assign light_ax    = a_reg.x;
  assign light_ay    = a_reg.y;
  assign light_az    = a_reg.z;
  assign light_bx    = b_reg.x;
  assign light_by    = b_reg.y;
  assign light_bz    = b_reg.z;
  assign light_cx    = c_reg.x;
  assign light_cy    = c_reg.y;
  assign light_cz    = c_reg.z;
  assign tri_vtx     = {c_reg.z, c_reg.y, c_reg.x,
                        b_reg.z, b_reg.y, b_reg.x,
                        a_reg.z, a_reg.y, a_reg.x};
  assign tri_shade   = shade_reg;
  assign tri_id      = id_reg;
  assign err_partial = err_reg;
endmodule

// File: tb/tb_tri_assembler.sv
// Bench for tri_assembler: queue-based primitive model plus directed tests.
module tb_tri_assembler;
  import tri_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           mode, vtx_valid, vtx_ready, vtx_last;
  logic [W-1:0]   vtx_x, vtx_y, vtx_z;
  logic [W-1:0]   light_ax, light_ay, light_az, light_bx, light_by, light_bz;
  logic [W-1:0]   light_cx, light_cy, light_cz;
  logic [SHW-1:0] light_shade;
  logic           tri_valid, tri_ready, err_partial;
  logic [9*W-1:0] tri_vtx, light_bus;
  logic [SHW-1:0] tri_shade;
  logic [IDW-1:0] tri_id;

  tri_assembler dut (
    .clk(clk), .rst(rst), .mode(mode), .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z), .vtx_last(vtx_last),
    .light_ax(light_ax), .light_ay(light_ay), .light_az(light_az),
    .light_bx(light_bx), .light_by(light_by), .light_bz(light_bz),
    .light_cx(light_cx), .light_cy(light_cy), .light_cz(light_cz),
    .light_shade(light_shade), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_vtx(tri_vtx), .tri_shade(tri_shade), .tri_id(tri_id), .err_partial(err_partial)
  );

  int total = 0;
  int bad   = 0;
  int shade_src = 0;  // 0 fake lighting, 1 constant 0x15, 2 free-running cycle count
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign light_bus = {light_cz, light_cy, light_cx, light_bz, light_by, light_bx,
                      light_az, light_ay, light_ax};

  // Stand-in lighting stage: facing triangles shade 17, back-facing 8.
  function automatic logic [SHW-1:0] lit(input int src, input logic [9*W-1:0] t, input int c);
    logic signed [W-1:0] ax, ay, bx, by, cx, cy;
    longint nz;
    ax = t[0*W +: W]; ay = t[1*W +: W];
    bx = t[3*W +: W]; by = t[4*W +: W];
    cx = t[6*W +: W]; cy = t[7*W +: W];
    nz = (longint'(bx) - longint'(ax)) * (longint'(cy) - longint'(ay))
       - (longint'(by) - longint'(ay)) * (longint'(cx) - longint'(ax));
    if (src == 0)      lit = (nz > 0) ? 6'd17 : 6'd8;
    else if (src == 1) lit = 6'h15;
    else               lit = c[SHW-1:0];
  endfunction

  assign light_shade = lit(shade_src, light_bus, cyc);

  function automatic logic [3*W-1:0] mk(input logic [W-1:0] x, y, z);
    mk = {z, y, x};
  endfunction

  task automatic chk(input string nm, input logic [9*W-1:0] act, input logic [9*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: keeps every vertex of the open primitive and derives triangles from counts.
  logic [3*W-1:0] prim[$];
  logic           m_mode, m_ready, m_valid, m_err, m_idle;
  logic [9*W-1:0] m_tri;
  logic [SHW-1:0] m_shade;
  logic [IDW-1:0] m_id;
  int             m_wait;

  initial begin
    int n, t;
    logic got;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        prim.delete();
        m_mode = 0; m_ready = 0; m_valid = 0; m_err = 0; m_idle = 1;
        m_tri = '0; m_shade = '0; m_id = '0; m_wait = 0;
      end else if (m_idle) begin
        m_idle = 0; m_ready = 1;
      end else if (m_ready) begin
        if (vtx_valid) begin
          got = 0;
          if (prim.size() == 0) m_mode = mode;
          prim.push_back(mk(vtx_x, vtx_y, vtx_z));
          n = prim.size();
          if (m_mode == MODE_LIST && n % 3 == 0) begin
            m_tri = {prim[n-1], prim[n-2], prim[n-3]}; got = 1;
          end else if (m_mode == MODE_STRIP && n >= 3) begin
            t = n - 3;
            if (t % 2 == 0) m_tri = {prim[n-1], prim[t+1], prim[t]};
            else            m_tri = {prim[n-1], prim[t], prim[t+1]};
            got = 1;
          end
          if (vtx_last) begin
            if (m_mode == MODE_LIST ? (n % 3 != 0) : (n < 3)) m_err = 1;
            prim.delete();
          end
          if (got) begin m_ready = 0; m_wait = SETTLE; end
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_shade = lit(shade_src, m_tri, cyc); m_valid = 1; end
      end else if (m_valid && tri_ready) begin
        m_valid = 0; m_id++; m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("vtx_ready", vtx_ready, m_ready);
      chk("tri_valid", tri_valid, m_valid);
      chk("light_bus", light_bus, m_tri);
      chk("err_partial", err_partial, m_err);
      if (m_valid) begin
        chk("tri_vtx", tri_vtx, m_tri);
        chk("tri_shade", tri_shade, m_shade);
        chk("tri_id", tri_id, m_id);
      end
    end
  end

  // Log of completed handshakes for literal checks.
  logic [9*W-1:0] log_vtx[$];
  logic [SHW-1:0] log_shade[$];
  logic [IDW-1:0] log_id[$];
  initial forever begin
    @(posedge clk);
    if (!rst && tri_valid && tri_ready) begin
      log_vtx.push_back(tri_vtx); log_shade.push_back(tri_shade); log_id.push_back(tri_id);
    end
  end

  task automatic send(input logic [W-1:0] x, y, z, input logic last);
    int n;
    logic acc;
    n = 0;
    vtx_valid = 1; vtx_x = x; vtx_y = y; vtx_z = z; vtx_last = last;
    do begin
      acc = vtx_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 300);
    if (!acc) begin total++; bad++; $display("FAIL send_timeout got=0 want=1"); end
    vtx_valid = 0; vtx_last = 0;
  endtask

  task automatic wait_log(input int want);
    int n;
    n = 0;
    while (log_id.size() < want && n < 300) begin @(negedge clk); n++; end
    chk("log_count", log_id.size(), want);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*W-1:0] snap_vtx;
    logic [SHW-1:0] snap_shade;
    logic [IDW-1:0] snap_id;
    int n;
    mode = MODE_LIST; vtx_valid = 0; vtx_last = 0; vtx_x = 0; vtx_y = 0; vtx_z = 0;
    tri_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_vtx_ready", vtx_ready, 0);
    chk("rst_tri_valid", tri_valid, 0);
    chk("rst_light", light_bus, 0);
    chk("rst_id", tri_id, 0);
    rst = 0;

    // List triangle, front-facing.
    shade_src = 0;
    send(16'h0000, 16'h0000, 16'h0000, 0);
    send(16'h0100, 16'h0000, 16'h0000, 0);
    send(16'h0000, 16'h0100, 16'h0000, 1);
    n = 0;
    while (!tri_valid && n < 50) begin @(negedge clk); n++; end
    chk("t1_latency", n, 4);
    wait_log(1);
    chk("t1_shade", log_shade[0], 17);
    chk("t1_id", log_id[0], 0);
    chk("t1_err", err_partial, 0);

    // Same vertices, reversed winding.
    send(16'h0000, 16'h0000, 16'h0000, 0);
    send(16'h0000, 16'h0100, 16'h0000, 0);
    send(16'h0100, 16'h0000, 16'h0000, 1);
    wait_log(2);
    chk("t2_shade", log_shade[1], 8);
    chk("t2_id", log_id[1], 1);

    // Strip of five; mode flips mid-primitive and must be ignored.
    shade_src = 1; mode = MODE_STRIP;
    send(16'h0010, 16'h0011, 16'h0012, 0);
    send(16'h0020, 16'h0021, 16'h0022, 0);
    send(16'h0030, 16'h0031, 16'h0032, 0);
    mode = MODE_LIST;
    send(16'h0040, 16'h0041, 16'h0042, 0);
    send(16'h0050, 16'h0051, 16'h0052, 1);
    wait_log(5);
    chk("s0_vtx", log_vtx[2], {mk(16'h0030, 16'h0031, 16'h0032), mk(16'h0020, 16'h0021, 16'h0022), mk(16'h0010, 16'h0011, 16'h0012)});
    chk("s1_vtx", log_vtx[3], {mk(16'h0040, 16'h0041, 16'h0042), mk(16'h0020, 16'h0021, 16'h0022), mk(16'h0030, 16'h0031, 16'h0032)});
    chk("s2_vtx", log_vtx[4], {mk(16'h0050, 16'h0051, 16'h0052), mk(16'h0040, 16'h0041, 16'h0042), mk(16'h0030, 16'h0031, 16'h0032)});
    chk("s2_shade", log_shade[4], 6'h15);
    chk("s2_id", log_id[4], 4);

    // Backpressure: hold tri_ready low in OUT while a vertex is offered.
    shade_src = 2; tri_ready = 0;
    send(16'hff00, 16'h0001, 16'h0002, 0);
    send(16'h0003, 16'hfe00, 16'h0004, 0);
    send(16'h0005, 16'h0006, 16'h8000, 0);
    n = 0;
    while (!tri_valid && n < 50) begin @(negedge clk); n++; end
    snap_vtx = tri_vtx; snap_shade = tri_shade; snap_id = tri_id;
    fork
      begin
        repeat (10) begin
          @(negedge clk);
          chk("hold_vtx", tri_vtx, snap_vtx);
          chk("hold_shade", tri_shade, snap_shade);
          chk("hold_id", tri_id, snap_id);
          chk("hold_ready", vtx_ready, 0);
        end
        tri_ready = 1;
      end
      send(16'h0007, 16'h0008, 16'h0009, 0);
    join
    chk("hold_accept_after", log_id.size(), 6);
    send(16'h000a, 16'h000b, 16'h000c, 0);
    send(16'h000d, 16'h000e, 16'h000f, 1);
    wait_log(7);

    // Short primitive flags err_partial and emits nothing.
    send(16'h0101, 16'h0102, 16'h0103, 0);
    send(16'h0201, 16'h0202, 16'h0203, 1);
    repeat (4) @(negedge clk);
    chk("err_set", err_partial, 1);
    chk("err_no_tri", log_id.size(), 7);
    send(16'h0301, 16'h0302, 16'h0303, 0);
    send(16'h0401, 16'h0402, 16'h0403, 0);
    send(16'h0501, 16'h0502, 16'h0503, 1);
    wait_log(8);
    chk("err_sticky", err_partial, 1);

    // Asynchronous reset during SETTLE.
    send(16'h0601, 16'h0602, 16'h0603, 0);
    send(16'h0701, 16'h0702, 16'h0703, 0);
    send(16'h0801, 16'h0802, 16'h0803, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_ready", vtx_ready, 0);
    chk("arst_valid", tri_valid, 0);
    chk("arst_light", light_bus, 0);
    chk("arst_vtx", tri_vtx, 0);
    chk("arst_shade", tri_shade, 0);
    chk("arst_id", tri_id, 0);
    chk("arst_err", err_partial, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("arst_no_tri", log_id.size(), 8);
    send(16'h0901, 16'h0902, 16'h0903, 0);
    send(16'h0a01, 16'h0a02, 16'h0a03, 0);
    send(16'h0b01, 16'h0b02, 16'h0b03, 1);
    wait_log(9);
    chk("arst_next_id", log_id[8], 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
